// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared state encoding and command codes for the burst RAM responder.
package burst_ram_pkg;

    typedef enum logic [4:0] {
        ST_INIT        = 5'b00001,
        ST_IDLE        = 5'b00010,
        ST_READ_WAIT   = 5'b00100,
        ST_READ_BURST  = 5'b01000,
        ST_WRITE_BURST = 5'b10000
    } br_state_t;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_mem.sv
// burst_ram_mem: single-port byte-masked word array with registered read; read data holds between reads.
module burst_ram_mem #(
  parameter int AW = 4,
  parameter int W = 64,
  parameter DATA_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [W-1:0]    wr_data,
  input  logic [W/8-1:0]  mask,
  output logic [W-1:0]    rd_data
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en && we)
      for (int i = 0; i < W/8; i++)
        if (!mask[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
  always_ff @(posedge clk)
    rd_data <= rst ? '0 : (en && !we) ? mem[addr] : rd_data;
endmodule

// File: rtl/burst_ram.sv
// burst_ram: burst-access RAM target of the br_* interface; one command at a time, COUNT beats per command.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH = 4,
    parameter int RAM_BURST_DATA_COUNT = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int CYCLES_BEFORE_DATA_VALID = 1,
    parameter int CYCLES_BEFORE_INITIATED = 8,
    parameter DATA_FILE = ""
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 br_cmd,
    input  logic                                 br_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                                 br_rd_data_valid,
    output logic                                 br_busy
);

    localparam int DW = RAM_DEPTH_BITWIDTH;
    localparam int BW = $clog2(RAM_BURST_DATA_COUNT + 1);
    localparam int LW = $clog2(CYCLES_BEFORE_DATA_VALID + 2);
    localparam int IW = $clog2(CYCLES_BEFORE_INITIATED + 2);

    br_state_t     state;
    logic [DW-1:0] base;
    logic [BW-1:0] beat;
    logic [LW-1:0] lat;
    logic [IW-1:0] init_cnt;
    logic          accept, lat_done, last_rd, rd_now, wr_now;
    logic [DW-1:0] mem_addr;

    // beat counts beats already issued, so base + beat is the next address in every state
    always_comb begin
        accept   = state == ST_IDLE && br_cmd_en;
        lat_done = lat == LW'(CYCLES_BEFORE_DATA_VALID - 1);
        last_rd  = beat == BW'(RAM_BURST_DATA_COUNT);
        wr_now   = (accept && br_cmd == BR_CMD_WRITE) || state == ST_WRITE_BURST;
        rd_now   = (accept && br_cmd == BR_CMD_READ && CYCLES_BEFORE_DATA_VALID == 0)
                || (state == ST_READ_WAIT && lat_done)
                || (state == ST_READ_BURST && !last_rd);
        mem_addr = accept ? br_addr : base + DW'(beat);
    end

    burst_ram_mem #(
        .AW(DW),
        .W(RAM_BURST_DATA_BITWIDTH),
        .DATA_FILE(DATA_FILE)
    ) u_mem (
        .clk(clk),
        .rst(rst),
        .en(!rst && (rd_now || wr_now)),
        .we(wr_now),
        .addr(mem_addr),
        .wr_data(br_wr_data),
        .mask(br_data_mask),
        .rd_data(br_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= CYCLES_BEFORE_INITIATED > 0 ? ST_INIT : ST_IDLE;
            br_busy          <= CYCLES_BEFORE_INITIATED > 0;
            br_rd_data_valid <= 1'b0;
            beat             <= '0;
            lat              <= '0;
            init_cnt         <= '0;
            base             <= '0;
        end else begin
            br_rd_data_valid <= rd_now;
            case (state)
                ST_INIT:
                    if (init_cnt == IW'(CYCLES_BEFORE_INITIATED - 1)) begin
                        state   <= ST_IDLE;
                        br_busy <= 1'b0;
                    end else
                        init_cnt <= init_cnt + IW'(1);
                ST_IDLE:
                    if (br_cmd_en) begin
                        base <= br_addr;
                        lat  <= '0;
                        if (br_cmd == BR_CMD_WRITE) begin
                            beat    <= BW'(1);
                            state   <= RAM_BURST_DATA_COUNT > 1 ? ST_WRITE_BURST : ST_IDLE;
                            br_busy <= RAM_BURST_DATA_COUNT > 1;
                        end else begin
                            beat    <= CYCLES_BEFORE_DATA_VALID == 0 ? BW'(1) : '0;
                            state   <= CYCLES_BEFORE_DATA_VALID == 0 ? ST_READ_BURST : ST_READ_WAIT;
                            br_busy <= 1'b1;
                        end
                    end
                ST_READ_WAIT:
                    if (lat_done) begin
                        beat  <= BW'(1);
                        state <= ST_READ_BURST;
                    end else
                        lat <= lat + LW'(1);
                // one extra cycle after the last beat so busy drops after valid
                ST_READ_BURST:
                    if (last_rd) begin
                        beat    <= '0;
                        state   <= ST_IDLE;
                        br_busy <= 1'b0;
                    end else
                        beat <= beat + BW'(1);
                ST_WRITE_BURST:
                    if (beat == BW'(RAM_BURST_DATA_COUNT - 1)) begin
                        beat    <= '0;
                        state   <= ST_IDLE;
                        br_busy <= 1'b0;
                    end else
                        beat <= beat + BW'(1);
                default: begin
                    state   <= ST_IDLE;
                    br_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: directed checks of init window, bursts, byte mask, wrap, busy collision and mid-burst reset.
module tb_burst_ram;

    typedef logic [63:0] beats_t [4];

    logic        clk = 1'b0;
    logic        rst, br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data, br_rd_data;
    logic [7:0]  br_data_mask;
    logic        br_rd_data_valid, br_busy;
    int          checks = 0, failures = 0;

    burst_ram dut (
        .clk(clk),
        .rst(rst),
        .br_cmd(br_cmd),
        .br_cmd_en(br_cmd_en),
        .br_addr(br_addr),
        .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input beats_t d, input logic [7:0] m);
        br_cmd_en = 1'b1; br_cmd = 1'b1; br_addr = a; br_wr_data = d[0]; br_data_mask = m;
        tick();
        br_cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            br_wr_data = d[k];
            chk("wr_busy_high", 64'(br_busy), 64'd1);
            tick();
        end
        chk("wr_busy_low", 64'(br_busy), 64'd0);
    endtask

    // collide: strobe a write to caddr during the second valid beat
    task automatic do_read(input logic [3:0] a, input beats_t e, input logic collide, input logic [3:0] caddr);
        br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = a;
        tick();
        br_cmd_en = 1'b0;
        chk("rd_wait_busy", 64'(br_busy), 64'd1);
        chk("rd_wait_valid", 64'(br_rd_data_valid), 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rd_valid", 64'(br_rd_data_valid), 64'd1);
            chk("rd_data", br_rd_data, e[k]);
            chk("rd_busy", 64'(br_busy), 64'd1);
            br_cmd_en = collide && k == 1;
            br_cmd = 1'b1; br_addr = caddr; br_wr_data = 64'hBADB_ADBA_DBAD_BADB; br_data_mask = 8'h00;
            tick();
            br_cmd_en = 1'b0;
        end
        chk("rd_end_valid", 64'(br_rd_data_valid), 64'd0);
        chk("rd_end_busy", 64'(br_busy), 64'd0);
        chk("rd_hold", br_rd_data, e[3]);
    endtask

    beats_t w2, ff4, z4, msk, wr14, at0;

    initial begin
        w2   = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        ff4  = '{default: 64'hFFFF_FFFF_FFFF_FFFF};
        z4   = '{default: 64'h0};
        msk  = '{default: 64'h0000_0000_FFFF_FFFF};
        wr14 = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1, 64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3};
        at0  = '{wr14[2], wr14[3], w2[0], w2[1]};
        rst = 1'b1; br_cmd = 1'b0; br_cmd_en = 1'b0; br_addr = '0; br_wr_data = '0; br_data_mask = '0;
        tick();
        tick();
        chk("rst_busy", 64'(br_busy), 64'd1);
        chk("rst_valid", 64'(br_rd_data_valid), 64'd0);
        chk("rst_rd_data", br_rd_data, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("init_busy", 64'(br_busy), 64'd1);
            chk("init_valid", 64'(br_rd_data_valid), 64'd0);
            br_cmd_en = i == 3; br_cmd = 1'b0;
            tick();
            br_cmd_en = 1'b0;
        end
        chk("init_done", 64'(br_busy), 64'd0);
        do_write(4'd2, w2, 8'h00);
        do_read(4'd2, w2, 1'b0, 4'd0);
        do_write(4'd6, ff4, 8'h00);
        do_write(4'd6, z4, 8'h0F);
        do_read(4'd6, msk, 1'b0, 4'd0);
        do_write(4'd14, wr14, 8'h00);
        do_read(4'd14, wr14, 1'b0, 4'd0);
        do_read(4'd0, at0, 1'b0, 4'd0);
        do_read(4'd2, w2, 1'b1, 4'd3);
        do_read(4'd2, w2, 1'b0, 4'd0);
        // reset on the second valid beat of a read
        br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = 4'd14;
        tick();
        br_cmd_en = 1'b0;
        tick();
        chk("mid_beat0", br_rd_data, wr14[0]);
        tick();
        chk("mid_beat1_valid", 64'(br_rd_data_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(br_rd_data_valid), 64'd0);
        chk("mid_rst_busy", 64'(br_busy), 64'd1);
        chk("mid_rst_data", br_rd_data, 64'd0);
        for (int i = 0; i < 20 && br_busy; i++) tick();
        chk("mid_rst_reinit", 64'(br_busy), 64'd0);
        do_read(4'd14, wr14, 1'b0, 4'd0);
        do_read(4'd6, msk, 1'b0, 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
